// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction
// memory and registers {pc, inst, valid} into the fetch/decode pipeline register.
// Redirects come from Execute (taken branch) and Decode (jump). A halt opcode
// stops sequential fetch after it has been handed to Decode once.
module fetch #(
    parameter int              ADDR_W   = 16,
    parameter int              INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'b1111
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              stall,
    input  logic              do_branch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              do_jump,
    input  logic [ADDR_W-1:0] jump_address,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_valid,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
    logic [ADDR_W-1:0] pc_inc_s;

    // True when the fetched word carries the halt opcode in its top nibble.
    function automatic logic is_halt_op(input logic [INST_W-1:0] word);
        return (word[INST_W-1 -: 4] == HALT_OP);
    endfunction

    assign pc_inc_s = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next fetch address: redirects first (branch is older than jump), then
    // boot address, then hold on stall/halt, else sequential (wraps naturally).
    always_comb begin
        imem_addr = pc_inc_s;
        if (do_branch) begin
            imem_addr = branch_target;
        end else if (do_jump) begin
            imem_addr = jump_address;
        end else if (state_q == ST_BOOT) begin
            imem_addr = RESET_PC;
        end else if (stall || (state_q == ST_HALTED)) begin
            imem_addr = pc_q;
        end else begin
            imem_addr = pc_inc_s;
        end
    end

    // pc_q always tracks the address whose data will appear on imem_data.
    assign pc_d = imem_addr;

    // Pipeline-register and state update; redirects squash the in-flight word
    // and also leave the halted state.
    always_comb begin
        state_d     = state_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        if (do_branch || do_jump) begin
            out_pc_d    = '0;
            out_inst_d  = '0;
            out_valid_d = 1'b0;
            state_d     = ST_RUN;
            halted_d    = 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    out_pc_d    = '0;
                    out_inst_d  = '0;
                    out_valid_d = 1'b0;
                    state_d     = ST_RUN;
                end
                ST_RUN: begin
                    if (stall) begin
                        state_d = ST_RUN;
                    end else begin
                        out_pc_d    = pc_q;
                        out_inst_d  = imem_data;
                        out_valid_d = 1'b1;
                        if (is_halt_op(imem_data)) begin
                            state_d  = ST_HALTED;
                            halted_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_HALTED: begin
                    if (stall) begin
                        state_d = ST_HALTED;
                    end else begin
                        out_pc_d    = '0;
                        out_inst_d  = '0;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    out_pc_d    = '0;
                    out_inst_d  = '0;
                    out_valid_d = 1'b0;
                    state_d     = ST_BOOT;
                end
            endcase
        end
    end

    // State, PC and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: a vector table for the steady-state,
// stall and redirect behaviour, plus hand-written halt, wrap and reset sequences.
module tb_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        do_branch;
    logic [15:0] branch_target;
    logic        do_jump;
    logic [15:0] jump_address;
    logic [15:0] out_pc;
    logic [15:0] out_inst;
    logic        out_valid;
    logic        halted;

    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] bt;
        logic        jp;
        logic [15:0] ja;
        logic [15:0] e_pc;
        logic [15:0] e_inst;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    vec_t vecs [12];

    fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .do_branch     (do_branch),
        .branch_target (branch_target),
        .do_jump       (do_jump),
        .jump_address  (jump_address),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_valid     (out_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory model.
    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] pc, input logic [15:0] inst,
                             input logic v, input logic h);
        check({tag, ".out_pc"},    {16'h0000, out_pc},    {16'h0000, pc});
        check({tag, ".out_inst"},  {16'h0000, out_inst},  {16'h0000, inst});
        check({tag, ".out_valid"}, {31'd0, out_valid},    {31'd0, v});
        check({tag, ".halted"},    {31'd0, halted},       {31'd0, h});
    endtask

    task automatic step(input logic s, input logic br, input logic [15:0] bt,
                        input logic jp, input logic [15:0] ja);
        stall         = s;
        do_branch     = br;
        branch_target = bt;
        do_jump       = jp;
        jump_address  = ja;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] halt_pcs  [6];
        logic [15:0] halt_insts[6];

        for (int i = 0; i < 65536; i++) begin
            mem[i] = {4'h3, i[11:0]};
        end
        mem[0] = 16'h1001;
        mem[1] = 16'h1002;
        mem[2] = 16'h1003;
        mem[3] = 16'h1004;
        mem[4] = 16'h1005;
        mem[5] = 16'hF000;

        //               stall br   bt        jp   ja        pc        inst      v     h
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h1001, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001, 16'h1002, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001, 16'h1002, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001, 16'h1002, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0002, 16'h1003, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0020, 16'h3020, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0021, 16'h3021, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h0040, 1'b1, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0040, 16'h3040, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0041, 16'h3041, 1'b1, 1'b0};

        halt_pcs   = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        halt_insts = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'hF000};

        stall = 1'b0; do_branch = 1'b0; branch_target = 16'h0000;
        do_jump = 1'b0; jump_address = 16'h0000;

        // Reset state, then the table: boot, stall, jump, branch+jump+stall.
        do_reset();
        check_out("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jp, vecs[i].ja);
            check_out($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst,
                      vecs[i].e_valid, vecs[i].e_halted);
        end

        // Halt: F000 delivered once, then frozen bubbles, then branch out.
        do_reset();
        idle();
        check_out("halt.boot", 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            idle();
            check_out($sformatf("halt.run%0d", i), halt_pcs[i], halt_insts[i], 1'b1, (i == 5));
        end
        for (int i = 0; i < 10; i++) begin
            idle();
            check_out($sformatf("halt.bub%0d", i), 16'h0000, 16'h0000, 1'b0, 1'b1);
            check($sformatf("halt.addr%0d", i), {16'h0000, imem_addr}, 32'h0000_0006);
        end
        step(1'b0, 1'b1, 16'h0008, 1'b0, 16'h0000);
        check_out("halt.brbub", 16'h0000, 16'h0000, 1'b0, 1'b0);
        idle();
        check_out("halt.br8", 16'h0008, 16'h3008, 1'b1, 1'b0);

        // PC wrap from 0xFFFF to 0x0000.
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF);
        check_out("wrap.bub", 16'h0000, 16'h0000, 1'b0, 1'b0);
        idle();
        check_out("wrap.ffff", 16'hFFFF, 16'h3FFF, 1'b1, 1'b0);
        idle();
        check_out("wrap.0000", 16'h0000, 16'h1001, 1'b1, 1'b0);
        idle();
        check_out("wrap.0001", 16'h0001, 16'h1002, 1'b1, 1'b0);

        // Asynchronous reset mid-stream clears outputs before any clock edge.
        #3;
        rst = 1'b1;
        #1;
        check_out("arst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        check("arst.addr", {16'h0000, imem_addr}, 32'h0000_0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        check_out("arst.boot", 16'h0000, 16'h0000, 1'b0, 1'b0);
        idle();
        check_out("arst.first", 16'h0000, 16'h1001, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
